// File: rtl/pc_gen.sv
// Fetch-stage program counter with stall, trap redirect, return-address stack
// and misaligned-target detection. All outputs except the RAS level flags are registered.
module pc_gen #(
    parameter int unsigned      XLEN      = 32,
    parameter logic [XLEN-1:0]  RESET_VEC = XLEN'(32'h0000_0000),
    parameter logic [XLEN-1:0]  TRAP_VEC  = XLEN'(32'h0000_0100),
    parameter int unsigned      INC       = 4,
    parameter int unsigned      RAS_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            jmp,
    input  logic            rel,
    input  logic [XLEN-1:0] diff,
    input  logic [XLEN-1:0] nxt,
    input  logic            call,
    input  logic            ret,
    input  logic            trap,
    output logic [XLEN-1:0] cur,
    output logic [XLEN-1:0] epc,
    output logic            ras_empty,
    output logic            ras_full,
    output logic            ras_uflow,
    output logic            misalign
);

    localparam int unsigned     PTR_W      = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned     CNT_W      = $clog2(RAS_DEPTH + 1);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(INC - 1);
    localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);
    localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(RAS_DEPTH);

    logic [XLEN-1:0]  r_cur;
    logic [XLEN-1:0]  r_epc;
    logic             r_uflow;
    logic             r_misalign;
    logic [XLEN-1:0]  r_ras [RAS_DEPTH];
    logic [PTR_W-1:0] r_ptr;
    logic [CNT_W-1:0] r_count;

    logic [XLEN-1:0]  w_cur_nxt;
    logic [XLEN-1:0]  w_epc_nxt;
    logic             w_uflow_nxt;
    logic             w_misalign_nxt;
    logic [XLEN-1:0]  w_seq;
    logic [XLEN-1:0]  w_rel_tgt;
    logic [XLEN-1:0]  w_top;
    logic [XLEN-1:0]  w_tgt;
    logic             w_redirect;
    logic             w_push;
    logic             w_pop;
    logic             w_replace;
    logic             w_empty;
    logic             w_full;
    logic [PTR_W-1:0] w_ptr_inc;
    logic [PTR_W-1:0] w_ptr_dec;

    // r_ptr is the next free slot; top of stack sits one below, wrapping circularly
    assign w_ptr_inc = (r_ptr == PTR_LAST) ? '0 : r_ptr + PTR_W'(1);
    assign w_ptr_dec = (r_ptr == '0) ? PTR_LAST : r_ptr - PTR_W'(1);
    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CNT_FULL);
    assign w_seq     = r_cur + INC_X;
    assign w_rel_tgt = r_cur + diff;
    assign w_top     = r_ras[w_ptr_dec];

    // Next-PC selection in priority order: trap, stall, ret, jmp, sequential
    always_comb begin
        w_cur_nxt      = r_cur;
        w_epc_nxt      = r_epc;
        w_uflow_nxt    = 1'b0;
        w_misalign_nxt = 1'b0;
        w_tgt          = '0;
        w_redirect     = 1'b0;
        w_push         = 1'b0;
        w_pop          = 1'b0;
        w_replace      = 1'b0;

        if (trap) begin
            w_cur_nxt = TRAP_VEC;
            w_epc_nxt = r_cur;
        end else if (stall) begin
            w_cur_nxt = r_cur;
        end else if (ret) begin
            w_redirect = 1'b1;
            if (w_empty) begin
                w_tgt       = nxt;
                w_uflow_nxt = 1'b1;
            end else begin
                w_tgt = w_top;
                // pop followed by push collapses to rewriting the top slot
                if (jmp && call) begin
                    w_replace = 1'b1;
                end else begin
                    w_pop = 1'b1;
                end
            end
        end else if (jmp) begin
            w_redirect = 1'b1;
            w_tgt      = rel ? w_rel_tgt : nxt;
            w_push     = call;
        end else begin
            w_cur_nxt = w_seq;
        end

        // A misaligned target leaves both the PC and the stack untouched
        if (w_redirect) begin
            if ((w_tgt & ALIGN_MASK) != '0) begin
                w_misalign_nxt = 1'b1;
                w_push         = 1'b0;
                w_pop          = 1'b0;
                w_replace      = 1'b0;
            end else begin
                w_cur_nxt = w_tgt;
            end
        end
    end

    // PC, exception PC and event pulses
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cur      <= RESET_VEC;
            r_epc      <= '0;
            r_uflow    <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_cur      <= w_cur_nxt;
            r_epc      <= w_epc_nxt;
            r_uflow    <= w_uflow_nxt;
            r_misalign <= w_misalign_nxt;
        end
    end

    // Return-address stack; a push when full overwrites the oldest entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr   <= '0;
            r_count <= '0;
            for (int i = 0; i < int'(RAS_DEPTH); i++) begin
                r_ras[i] <= '0;
            end
        end else if (w_push) begin
            r_ras[r_ptr] <= w_seq;
            r_ptr        <= w_ptr_inc;
            if (!w_full) begin
                r_count <= r_count + CNT_W'(1);
            end
        end else if (w_pop) begin
            r_ptr   <= w_ptr_dec;
            r_count <= r_count - CNT_W'(1);
        end else if (w_replace) begin
            r_ras[w_ptr_dec] <= w_seq;
        end
    end

    assign cur       = r_cur;
    assign epc       = r_epc;
    assign ras_uflow = r_uflow;
    assign misalign  = r_misalign;
    assign ras_empty = w_empty;
    assign ras_full  = w_full;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen: sequential flow, jumps, call/return, RAS overflow,
// priority and wrap-around, all against hand-computed PCs.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        jmp;
    logic        rel;
    logic [31:0] diff;
    logic [31:0] nxt;
    logic        call;
    logic        ret;
    logic        trap;
    logic [31:0] cur;
    logic [31:0] epc;
    logic        ras_empty;
    logic        ras_full;
    logic        ras_uflow;
    logic        misalign;

    int n_checks = 0;
    int n_errors = 0;

    pc_gen u_dut (
        .clk       (clk),
        .rst       (rst),
        .stall     (stall),
        .jmp       (jmp),
        .rel       (rel),
        .diff      (diff),
        .nxt       (nxt),
        .call      (call),
        .ret       (ret),
        .trap      (trap),
        .cur       (cur),
        .epc       (epc),
        .ras_empty (ras_empty),
        .ras_full  (ras_full),
        .ras_uflow (ras_uflow),
        .misalign  (misalign)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Apply one cycle of inputs, then sample 1 ns after the edge with inputs idle
    task automatic step(input logic s, input logic j, input logic r,
                        input logic [31:0] d, input logic [31:0] n,
                        input logic c, input logic rt, input logic t);
        stall = s; jmp = j; rel = r; diff = d; nxt = n; call = c; ret = rt; trap = t;
        @(posedge clk);
        #1;
        stall = 1'b0; jmp = 1'b0; rel = 1'b0; diff = '0; nxt = '0;
        call = 1'b0; ret = 1'b0; trap = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic jump_abs(input logic [31:0] n, input logic c);
        step(1'b0, 1'b1, 1'b0, 32'h0, n, c, 1'b0, 1'b0);
    endtask

    task automatic do_ret(input logic [31:0] n);
        step(1'b0, 1'b0, 1'b0, 32'h0, n, 1'b0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h404; ret_exp[1] = 32'h304; ret_exp[2] = 32'h204; ret_exp[3] = 32'h104;

        rst = 1'b0; stall = 1'b0; jmp = 1'b0; rel = 1'b0; diff = '0; nxt = '0;
        call = 1'b0; ret = 1'b0; trap = 1'b0;

        // reset state
        #2;
        check("rst_cur", cur, 32'h0);
        check("rst_epc", epc, 32'h0);
        check("rst_empty", 32'(ras_empty), 32'h1);
        check("rst_full", 32'(ras_full), 32'h0);
        check("rst_uflow", 32'(ras_uflow), 32'h0);
        check("rst_misalign", 32'(misalign), 32'h0);
        #10 rst = 1'b1;

        // sequential
        idle(); check("seq_4", cur, 32'h4);
        idle(); check("seq_8", cur, 32'h8);
        idle(); check("seq_c", cur, 32'hC);

        // asynchronous reset mid-run, no clock edge needed
        #3 rst = 1'b0;
        #1 check("async_rst_cur", cur, 32'h0);
        #1 rst = 1'b1;
        idle(); check("post_rst_seq", cur, 32'h4);

        // relative / absolute jumps, misaligned target
        jump_abs(32'h40, 1'b0); check("jmp_abs_40", cur, 32'h40);
        step(1'b0, 1'b1, 1'b1, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0, 1'b0);
        check("jmp_rel_neg", cur, 32'h30);
        jump_abs(32'h200, 1'b0); check("jmp_abs_200", cur, 32'h200);
        check("aligned_no_mis", 32'(misalign), 32'h0);
        jump_abs(32'h202, 1'b0); check("mis_hold_cur", cur, 32'h200);
        check("mis_pulse", 32'(misalign), 32'h1);
        idle(); check("mis_clear", 32'(misalign), 32'h0);
        check("mis_then_seq", cur, 32'h204);

        // call / return / underflow
        jump_abs(32'h10, 1'b0); check("to_10", cur, 32'h10);
        jump_abs(32'h80, 1'b1); check("call_cur", cur, 32'h80);
        check("call_not_empty", 32'(ras_empty), 32'h0);
        do_ret(32'h0); check("ret_cur", cur, 32'h14);
        check("ret_empty", 32'(ras_empty), 32'h1);
        do_ret(32'h300); check("uflow_cur", cur, 32'h300);
        check("uflow_pulse", 32'(ras_uflow), 32'h1);
        idle(); check("uflow_clear", 32'(ras_uflow), 32'h0);
        check("uflow_seq", cur, 32'h304);

        // RAS overflow: five calls into a four-entry stack
        jump_abs(32'h0, 1'b0); check("to_0", cur, 32'h0);
        for (int i = 0; i < 5; i++) begin
            jump_abs(32'((i + 1) * 32'h100), 1'b1);
        end
        check("ovf_cur", cur, 32'h500);
        check("ovf_full", 32'(ras_full), 32'h1);
        for (int i = 0; i < 4; i++) begin
            do_ret(32'h0);
            check($sformatf("ovf_ret%0d", i), cur, ret_exp[i]);
        end
        check("ovf_empty", 32'(ras_empty), 32'h1);
        check("ovf_not_full", 32'(ras_full), 32'h0);

        // stall blocks jmp
        step(1'b1, 1'b1, 1'b0, 32'h0, 32'h800, 1'b0, 1'b0, 1'b0);
        check("stall_jmp", cur, 32'h104);

        // trap beats stall and ret; RAS untouched
        jump_abs(32'h24, 1'b1); check("to_24_call", cur, 32'h24);
        step(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b1);
        check("trap_cur", cur, 32'h100);
        check("trap_epc", epc, 32'h24);
        check("trap_ras_kept", 32'(ras_empty), 32'h0);
        do_ret(32'h0); check("trap_ret_top", cur, 32'h108);
        check("trap_ret_empty", 32'(ras_empty), 32'h1);

        // jmp+call+ret replaces top with cur+INC
        jump_abs(32'h4C, 1'b0); check("to_4c", cur, 32'h4C);
        jump_abs(32'h60, 1'b1); check("call_to_60", cur, 32'h60);
        step(1'b0, 1'b1, 1'b0, 32'h0, 32'h900, 1'b1, 1'b1, 1'b0);
        check("jcr_cur", cur, 32'h50);
        check("jcr_not_empty", 32'(ras_empty), 32'h0);
        do_ret(32'h0); check("jcr_new_top", cur, 32'h64);
        check("jcr_empty", 32'(ras_empty), 32'h1);

        // call without jmp is ignored
        step(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        check("call_only_seq", cur, 32'h68);
        check("call_only_empty", 32'(ras_empty), 32'h1);

        // wrap-around
        jump_abs(32'hFFFF_FFFC, 1'b0); check("to_top", cur, 32'hFFFF_FFFC);
        idle(); check("wrap", cur, 32'h0);
        check("epc_hold", epc, 32'h24);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
